// File: rtl/subservient_gpio_pkg.sv
// subservient_gpio_pkg
//   Shared definitions for the Wishbone GPIO / interrupt controller:
//   register offsets (word index adr[4:2]), reset value, edge-mode enum
//   and the byte-select expansion helper.
//   Optional feature macro: SUBSERVIENT_GPIO_IRQ_EN (see subservient_gpio_wb).
package subservient_gpio_pkg;

    localparam int unsigned REG_IDX_W = 3;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_DOUT     = 3'd0;
    localparam reg_idx_t REG_OE       = 3'd1;
    localparam reg_idx_t REG_DIN      = 3'd2;
    localparam reg_idx_t REG_IRQ_EN   = 3'd3;
    localparam reg_idx_t REG_IRQ_EDGE = 3'd4;
    localparam reg_idx_t REG_IRQ_STAT = 3'd5;

    // Every register (and the bus read data) resets to zero.
    localparam logic [31:0] REG_RST_VAL = 32'h0000_0000;

    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } edge_mode_e;

    // Expand the four Wishbone byte-lane selects into a 32-bit write mask.
    function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/subservient_gpio_sync.sv
// subservient_gpio_sync
//   One GPIO input channel: two-flop synchroniser for the asynchronous pad,
//   plus (when SUBSERVIENT_GPIO_IRQ_EN is defined) a prev flop and edge
//   detector producing a one-cycle event on the selected edge.
//   Ports:
//     i_clk, i_rst  clock, synchronous active-high reset
//     i_pad         asynchronous pad input
//     i_edge        EDGE_RISE / EDGE_FALL event selection
//     o_sync        synchronised pad value
//     o_event       one-cycle pulse on the selected edge (0 when IRQs absent)
module subservient_gpio_sync
    import subservient_gpio_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pad,
    input  edge_mode_e i_edge,
    output logic       o_sync,
    output logic       o_event
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_pad;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

`ifdef SUBSERVIENT_GPIO_IRQ_EN
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= r_sync;
        end
    end

    assign o_event = (i_edge == EDGE_FALL) ? (~r_sync &  r_prev)
                                           : ( r_sync & ~r_prev);
`else
    logic w_unused;
    assign w_unused = i_edge;
    assign o_event  = 1'b0;
`endif

endmodule

// File: rtl/subservient_gpio_wb.sv
// subservient_gpio_wb
//   Wishbone-mapped N_IO-channel GPIO with optional edge interrupts.
//   Optional feature macro: SUBSERVIENT_GPIO_IRQ_EN -- when defined, IRQ_EN,
//   IRQ_EDGE, IRQ_STAT and irq_o are implemented; otherwise they read 0,
//   ignore writes and irq_o is tied low.
//   Ports:
//     wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//     wbs_cyc/stb/we/sel/adr/dat_i  Wishbone slave request
//     wbs_dat_o, wbs_ack_o     read data (0 unless acking), single-cycle ack
//     io_in                    asynchronous pad inputs
//     io_out, io_oeb           pad output value, active-low output enable
//     irq_o                    level interrupt, |(IRQ_STAT & IRQ_EN)
module subservient_gpio_wb
    import subservient_gpio_pkg::*;
#(
    parameter int unsigned N_IO      = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFE0
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic [31:0]     wbs_dat_o,
    output logic            wbs_ack_o,
    input  logic [N_IO-1:0] io_in,
    output logic [N_IO-1:0] io_out,
    output logic [N_IO-1:0] io_oeb,
    output logic            irq_o
);

    logic            w_hit;
    logic            w_acc;
    logic            w_wr;
    reg_idx_t        w_idx;
    logic [31:0]     w_wmask;
    logic [31:0]     w_rd;
    logic [N_IO-1:0] w_bmask;
    logic [N_IO-1:0] w_wdat;
    logic [N_IO-1:0] w_din;
    logic [N_IO-1:0] w_event;

    logic [N_IO-1:0] r_dout;
    logic [N_IO-1:0] r_oe;
    logic            r_ack;
    logic [31:0]     r_dat;

    // A request is accepted only while ack is low, so a held cyc&stb gets
    // an ack every second cycle and each access is performed exactly once.
    assign w_hit   = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    assign w_acc   = w_hit & ~r_ack;
    assign w_wr    = w_acc & wbs_we_i;
    assign w_idx   = wbs_adr_i[4:2];
    assign w_wmask = sel_to_mask(wbs_sel_i);
    assign w_bmask = w_wmask[N_IO-1:0];
    assign w_wdat  = wbs_dat_i[N_IO-1:0];

`ifdef SUBSERVIENT_GPIO_IRQ_EN
    logic [N_IO-1:0] r_irq_en;
    logic [N_IO-1:0] r_irq_edge;
    logic [N_IO-1:0] r_irq_stat;
    logic [N_IO-1:0] w_w1c;

    assign w_w1c = (w_wr && w_idx == REG_IRQ_STAT) ? (w_wdat & w_bmask) : '0;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_irq_en   <= REG_RST_VAL[N_IO-1:0];
            r_irq_edge <= REG_RST_VAL[N_IO-1:0];
            r_irq_stat <= REG_RST_VAL[N_IO-1:0];
        end else begin
            if (w_wr && w_idx == REG_IRQ_EN)
                r_irq_en <= (r_irq_en & ~w_bmask) | (w_wdat & w_bmask);
            if (w_wr && w_idx == REG_IRQ_EDGE)
                r_irq_edge <= (r_irq_edge & ~w_bmask) | (w_wdat & w_bmask);
            // Set is OR-ed in after the clear so a same-cycle event wins.
            r_irq_stat <= (r_irq_stat & ~w_w1c) | (w_event & r_irq_en);
        end
    end

    assign irq_o = |(r_irq_stat & r_irq_en);
`else
    assign irq_o = 1'b0;
`endif

    for (genvar g = 0; g < N_IO; g++) begin : g_ch
        edge_mode_e w_mode;
`ifdef SUBSERVIENT_GPIO_IRQ_EN
        assign w_mode = r_irq_edge[g] ? EDGE_FALL : EDGE_RISE;
`else
        assign w_mode = EDGE_RISE;
`endif
        subservient_gpio_sync u_sync (
            .i_clk   (wb_clk_i),
            .i_rst   (wb_rst_i),
            .i_pad   (io_in[g]),
            .i_edge  (w_mode),
            .o_sync  (w_din[g]),
            .o_event (w_event[g])
        );
    end

    always_comb begin
        w_rd = '0;
        case (w_idx)
            REG_DOUT:     w_rd[N_IO-1:0] = r_dout;
            REG_OE:       w_rd[N_IO-1:0] = r_oe;
            REG_DIN:      w_rd[N_IO-1:0] = w_din;
`ifdef SUBSERVIENT_GPIO_IRQ_EN
            REG_IRQ_EN:   w_rd[N_IO-1:0] = r_irq_en;
            REG_IRQ_EDGE: w_rd[N_IO-1:0] = r_irq_edge;
            REG_IRQ_STAT: w_rd[N_IO-1:0] = r_irq_stat;
`endif
            default:      w_rd = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_dout <= REG_RST_VAL[N_IO-1:0];
            r_oe   <= REG_RST_VAL[N_IO-1:0];
            r_ack  <= 1'b0;
            r_dat  <= REG_RST_VAL;
        end else begin
            if (w_wr && w_idx == REG_DOUT)
                r_dout <= (r_dout & ~w_bmask) | (w_wdat & w_bmask);
            if (w_wr && w_idx == REG_OE)
                r_oe <= (r_oe & ~w_bmask) | (w_wdat & w_bmask);
            r_ack <= w_acc;
            r_dat <= w_acc ? w_rd : '0;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign io_out    = r_dout;
    assign io_oeb    = ~r_oe;

    // Upper data/mask bits beyond N_IO and unused event lines are dropped.
    logic w_unused;
    assign w_unused = ^{wbs_dat_i, w_wmask, w_event};

endmodule
